// File: rtl/cu_pkg.sv
// Shared definitions for the hardwired control sequencer: the state encoding,
// the opcode and ALU codes, the enable-bit positions and the opcode-to-ALU mapping.
package cu_pkg;

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_T0    = 4'd1,
    S_T1    = 4'd2,
    S_T2    = 4'd3,
    S_T3    = 4'd4,
    S_T4    = 4'd5,
    S_T5    = 4'd6,
    S_HALT  = 4'd7,
    S_FAULT = 4'd8
  } state_e;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b01001;
  localparam logic [4:0] OP_OR   = 5'b01010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [4:0] ALU_ADD = 5'd1;
  localparam logic [4:0] ALU_SUB = 5'd2;
  localparam logic [4:0] ALU_AND = 5'd3;
  localparam logic [4:0] ALU_OR  = 5'd4;
  localparam logic [4:0] ALU_NOP = 5'd7;

  localparam int unsigned EN_ZLOWIN = 19;
  localparam int unsigned EN_PCIN   = 20;
  localparam int unsigned EN_IRIN   = 21;
  localparam int unsigned EN_MDRIN  = 22;
  localparam int unsigned EN_MARIN  = 23;
  localparam int unsigned EN_YIN    = 24;

  // True for the opcodes that run the three-operand register ALU sequence.
  function automatic logic is_alu_op(input logic [4:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
  endfunction

  // ALU operation code for a supported opcode; NOP for anything else.
  function automatic logic [4:0] alu_map(input logic [4:0] op);
    case (op)
      OP_ADD:  return ALU_ADD;
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      OP_OR:   return ALU_OR;
      default: return ALU_NOP;
    endcase
  endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Datapath and memory-handshake bundle between the control sequencer (master)
// and the datapath / memory responder side (slave).
interface control_sequencer_if #(
  parameter int unsigned ENW = 32
);
  logic [31:0]    IR;
  logic           mem_ready;
  logic [ENW-1:0] i;
  logic [15:0]    Rout;
  logic           PCout;
  logic           Zlowout;
  logic           MDRout;
  logic           Read;
  logic           IncPC;
  logic [4:0]     ALU_Sel;

  modport master (
    input  IR, mem_ready,
    output i, Rout, PCout, Zlowout, MDRout, Read, IncPC, ALU_Sel
  );

  modport slave (
    output IR, mem_ready,
    input  i, Rout, PCout, Zlowout, MDRout, Read, IncPC, ALU_Sel
  );
endinterface

// File: rtl/reg_sel_decode.sv
// 4-bit register index plus enable to a 16-bit one-hot select.
module reg_sel_decode (
  input  logic [3:0]  idx_i,
  input  logic        en_i,
  output logic [15:0] onehot_o
);

  // One bit set at the indexed position when enabled, otherwise all clear.
  always_comb begin
    onehot_o = '0;
    if (en_i) onehot_o[idx_i] = 1'b1;
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control unit: fetch (T0-T2), decode (T3), register ALU sequence
// (T4-T5), with memory-wait timeout into FAULT and a terminal HALT state.
module control_sequencer
  import cu_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned ENW         = 32
) (
  input  logic                Clock,
  input  logic                clr,
  input  logic                run,
  control_sequencer_if.master cu,
  output logic                halted,
  output logic                fault,
  output logic [3:0]          state_dbg
);

  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [7:0] wait_q, wait_d;

  logic [4:0] opcode;
  logic [3:0] ra, rb, rc;
  logic       op_alu;
  logic       unused_ir;

  assign opcode    = cu.IR[31:27];
  assign ra        = cu.IR[26:23];
  assign rb        = cu.IR[22:19];
  assign rc        = cu.IR[18:15];
  assign op_alu    = is_alu_op(opcode);
  assign unused_ir = ^cu.IR[14:0];

  // Next-state and memory-wait counter logic.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    case (state_q)
      S_IDLE: if (run) state_d = S_T0;
      S_T0:   state_d = S_T1;
      S_T1: begin
        if (cu.mem_ready) begin
          state_d = S_T2;
          wait_d  = '0;
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_FAULT;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_T2:   state_d = S_T3;
      S_T3: begin
        if (opcode == OP_HALT) state_d = S_HALT;
        else if (op_alu)       state_d = S_T4;
        else                   state_d = S_T0;
      end
      S_T4:    state_d = S_T5;
      S_T5:    state_d = run ? S_T0 : S_IDLE;
      S_HALT:  state_d = S_HALT;
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_IDLE;
    endcase
  end

  // State and counter registers with synchronous active-low clear.
  always_ff @(posedge Clock) begin
    if (!clr) begin
      state_q <= S_IDLE;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  logic [15:0] rout_sel, reg_wr;
  logic [3:0]  rout_idx;
  logic        rout_en;

  // rb is read in T3 (into Y), rc in T4 (into the ALU); ra is written in T5.
  assign rout_idx = (state_q == S_T4) ? rc : rb;
  assign rout_en  = ((state_q == S_T3) && op_alu) || (state_q == S_T4);

  reg_sel_decode u_rout_dec (
    .idx_i    (rout_idx),
    .en_i     (rout_en),
    .onehot_o (rout_sel)
  );

  reg_sel_decode u_rin_dec (
    .idx_i    (ra),
    .en_i     (state_q == S_T5),
    .onehot_o (reg_wr)
  );

  logic [ENW-1:0] en_vec;
  logic           pcout, zlowout, mdrout, rd, incpc;
  logic [4:0]     alu_sel;

  // Moore output decode; PCin in T1 is qualified by mem_ready so PC loads once.
  always_comb begin
    en_vec        = '0;
    en_vec[15:0]  = reg_wr;
    pcout         = 1'b0;
    zlowout       = 1'b0;
    mdrout        = 1'b0;
    rd            = 1'b0;
    incpc         = 1'b0;
    alu_sel       = ALU_NOP;
    case (state_q)
      S_T0: begin
        pcout             = 1'b1;
        incpc             = 1'b1;
        en_vec[EN_MARIN]  = 1'b1;
        en_vec[EN_ZLOWIN] = 1'b1;
      end
      S_T1: begin
        zlowout          = 1'b1;
        rd               = 1'b1;
        en_vec[EN_MDRIN] = 1'b1;
        en_vec[EN_PCIN]  = cu.mem_ready;
      end
      S_T2: begin
        mdrout          = 1'b1;
        en_vec[EN_IRIN] = 1'b1;
      end
      S_T3: en_vec[EN_YIN] = op_alu;
      S_T4: begin
        alu_sel           = alu_map(opcode);
        en_vec[EN_ZLOWIN] = 1'b1;
      end
      S_T5:    zlowout = 1'b1;
      default: ;
    endcase
  end

  assign cu.i       = en_vec;
  assign cu.Rout    = rout_sel;
  assign cu.PCout   = pcout;
  assign cu.Zlowout = zlowout;
  assign cu.MDRout  = mdrout;
  assign cu.Read    = rd;
  assign cu.IncPC   = incpc;
  assign cu.ALU_Sel = alu_sel;

  assign halted    = (state_q == S_HALT);
  assign fault     = (state_q == S_FAULT);
  assign state_dbg = state_q;

endmodule
